// File: rtl/fifo_wr_ctrl_p_if.sv
// Write-side bundle of the dual-clock FIFO: request/clear inputs, memory
// write port and status returned by the write-domain controller.
interface fifo_wr_ctrl_p_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  inc;
    logic [ADDR_WIDTH:0]   sync_rptr;
    logic                  clr_ovf;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   gray_w_ptr;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   free_cnt;
    logic                  overflow;

    modport master (
        input  inc, sync_rptr, clr_ovf,
        output wen, waddr, gray_w_ptr, full, almost_full, free_cnt, overflow
    );

    modport slave (
        output inc, sync_rptr, clr_ovf,
        input  wen, waddr, gray_w_ptr, full, almost_full, free_cnt, overflow
    );
endinterface

// File: rtl/fifo_wr_ctrl_p.sv
// Write-domain controller of the dual-clock FIFO: write pointer (binary and
// Gray), registered full / almost_full / free count and sticky overflow.
module fifo_wr_ctrl_p #(
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_THRESH = 2
) (
    input  logic clk,
    input  logic rst,
    fifo_wr_ctrl_p_if.master bus
);
    localparam int             PW      = ADDR_WIDTH + 1;
    localparam int             DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0]  DEPTH_V = PW'(DEPTH);
    localparam logic [PW-1:0]  THR_V   = PW'(AFULL_THRESH);

    logic [PW-1:0] w_bin;
    logic [PW-1:0] w_bin_nxt;
    logic [PW-1:0] w_gray_nxt;
    logic [PW-1:0] r_bin;
    logic [PW-1:0] rptr_wrapped;
    logic [PW-1:0] free_nxt;
    logic [PW-1:0] gray_q;
    logic [PW-1:0] free_q;
    logic          full_q;
    logic          afull_q;
    logic          ovf_q;
    logic          wen;

    // Uses only the registered full flag, so sync_rptr never reaches wen.
    assign wen        = bus.inc & ~full_q;
    assign w_bin_nxt  = w_bin + PW'(wen);
    assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

    // Full pattern: read pointer one lap behind, i.e. top two Gray bits inverted.
    assign rptr_wrapped = {~bus.sync_rptr[PW-1:PW-2], bus.sync_rptr[PW-3:0]};

    // NOTE: every bit is assigned before use in always_comb, so no latch is inferred.
    always_comb begin
        r_bin = '0;
        for (int i = 0; i < PW; i++) begin
            r_bin[i] = ^(bus.sync_rptr >> i);
        end
    end

    assign free_nxt = DEPTH_V - (w_bin_nxt - r_bin);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_bin   <= '0;
            gray_q  <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            free_q  <= DEPTH_V;
            ovf_q   <= 1'b0;
        end else begin
            w_bin   <= w_bin_nxt;
            gray_q  <= w_gray_nxt;
            full_q  <= (w_gray_nxt == rptr_wrapped);
            afull_q <= (free_nxt <= THR_V);
            free_q  <= free_nxt;
            // Set has priority over clear.
            if (bus.inc && full_q) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.wen         = wen;
    assign bus.waddr       = w_bin[ADDR_WIDTH-1:0];
    assign bus.gray_w_ptr  = gray_q;
    assign bus.full        = full_q;
    assign bus.almost_full = afull_q;
    assign bus.free_cnt    = free_q;
    assign bus.overflow    = ovf_q;
endmodule
